// File: rtl/multih_phase_detector.sv
// Purpose : symbol-rate carrier phase detector; CORDIC vectoring atan of derotated I/Q minus trellis reference phase.
// Latency : phaseErrorEn rises ITER+3 clocks after the edge that samples symEn (15 at ITER=12).
// Backpr. : none; symEn while busy is dropped and flagged on sticky overrun. Build option MULTIH_PHERR_LIMIT_EN clamps the error to +/-errLimit.
module multih_phase_detector #(
    parameter int ITER  = 12,
    parameter int ACC_W = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        symEn,
    input  logic [17:0] iIn,
    input  logic [17:0] qIn,
    input  logic [7:0]  refPhase,
    input  logic        refValid,
    input  logic [11:0] magThreshold,
    input  logic [6:0]  errLimit,
    input  logic        clrOverrun,
    output logic [7:0]  phaseError,
    output logic        phaseErrorEn,
    output logic        phaseErrorValid,
    output logic        busy,
    output logic        overrun
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_ROT  = 3'd2;
    localparam logic [2:0] S_POST = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    localparam logic [3:0] K_LAST = 4'(ITER - 1);
    localparam int         MW     = (ACC_W - 8 > 12) ? (ACC_W - 8) : 12;

    logic [2:0]              state_q, state_d;
    logic signed [ACC_W-1:0] x_q, x_d, y_q, y_d;
    logic [15:0]             z_q, z_d;
    logic [3:0]              k_q, k_d;
    logic [7:0]              ref_q, ref_d;
    logic                    refv_q, refv_d;
    logic                    zero_q, zero_d;
    logic [7:0]              e8_q, e8_d;
    logic                    valid_q, valid_d;
    logic [7:0]              pe_q, pe_d;
    logic                    pv_q, pv_d;
    logic                    en_q, en_d;
    logic                    ovr_q, ovr_d;

    logic signed [ACC_W-1:0] xs, ys;
    logic [15:0]             z_eff, e16;
    logic [7:0]              e8_rnd, e8_fin;
    logic                    mag_ok;

    // Elementary angles atan(2^-k), 65536 counts per turn.
    function automatic logic [15:0] atan_lut(input logic [3:0] k);
        case (k)
            4'd0:    atan_lut = 16'd8192;
            4'd1:    atan_lut = 16'd4836;
            4'd2:    atan_lut = 16'd2555;
            4'd3:    atan_lut = 16'd1297;
            4'd4:    atan_lut = 16'd651;
            4'd5:    atan_lut = 16'd326;
            4'd6:    atan_lut = 16'd163;
            4'd7:    atan_lut = 16'd81;
            4'd8:    atan_lut = 16'd41;
            4'd9:    atan_lut = 16'd20;
            4'd10:   atan_lut = 16'd10;
            4'd11:   atan_lut = 16'd5;
            4'd12:   atan_lut = 16'd3;
            4'd13:   atan_lut = 16'd1;
            default: atan_lut = 16'd0;
        endcase
    endfunction

    assign xs = x_q >>> k_q;
    assign ys = y_q >>> k_q;

    // Wrapped error, round half up with +127 saturation, optional clamp, and magnitude gate.
    always_comb begin
        // A null vector would drive every micro-rotation the same way and
        // accumulate the whole table, so its angle is forced to zero.
        z_eff = zero_q ? 16'h0000 : z_q;
        e16   = z_eff - {ref_q, 8'h00};
        if (e16[15:8] == 8'h7F && e16[7]) begin
            e8_rnd = 8'h7F;
        end else begin
            e8_rnd = e16[15:8] + {7'd0, e16[7]};
        end
        mag_ok = refv_q && (MW'(x_q[ACC_W-1:8]) >= MW'(magThreshold));
    end

`ifdef MULTIH_PHERR_LIMIT_EN
    logic [7:0] lim_pos, lim_neg;
    // Symmetric clamp of the rounded error to +/-errLimit.
    always_comb begin
        lim_pos = {1'b0, errLimit};
        lim_neg = 8'd0 - lim_pos;
        if ($signed(e8_rnd) > $signed(lim_pos)) begin
            e8_fin = lim_pos;
        end else if ($signed(e8_rnd) < $signed(lim_neg)) begin
            e8_fin = lim_neg;
        end else begin
            e8_fin = e8_rnd;
        end
    end
`else
    logic unused_errlimit;
    assign unused_errlimit = ^errLimit;
    assign e8_fin = e8_rnd;
`endif

    // FSM and datapath next state: capture, fold, ITER micro-rotations, error, publish.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        k_d     = k_q;
        ref_d   = ref_q;
        refv_d  = refv_q;
        zero_d  = zero_q;
        e8_d    = e8_q;
        valid_d = valid_q;
        pe_d    = pe_q;
        pv_d    = pv_q;
        en_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (symEn) begin
                    x_d     = {{(ACC_W-18){iIn[17]}}, iIn};
                    y_d     = {{(ACC_W-18){qIn[17]}}, qIn};
                    ref_d   = refPhase;
                    refv_d  = refValid;
                    zero_d  = (iIn == 18'd0) && (qIn == 18'd0);
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                // Fold the left half-plane onto the right so the rotations converge.
                if (x_q[ACC_W-1]) begin
                    x_d = -x_q;
                    y_d = -y_q;
                    z_d = 16'h8000;
                end else begin
                    z_d = 16'h0000;
                end
                k_d     = 4'd0;
                state_d = S_ROT;
            end
            S_ROT: begin
                if (!y_q[ACC_W-1]) begin
                    x_d = x_q + ys;
                    y_d = y_q - xs;
                    z_d = z_q + atan_lut(k_q);
                end else begin
                    x_d = x_q - ys;
                    y_d = y_q + xs;
                    z_d = z_q - atan_lut(k_q);
                end
                if (k_q == K_LAST) begin
                    state_d = S_POST;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            S_POST: begin
                e8_d    = e8_fin;
                valid_d = mag_ok;
                state_d = S_OUT;
            end
            S_OUT: begin
                pe_d    = e8_q;
                pv_d    = valid_q;
                en_d    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sticky overrun: a new event beats a simultaneous clear.
    always_comb begin
        if (symEn && (state_q != S_IDLE)) begin
            ovr_d = 1'b1;
        end else if (clrOverrun) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // State registers; reset aborts any computation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            k_q     <= '0;
            ref_q   <= '0;
            refv_q  <= 1'b0;
            zero_q  <= 1'b0;
            e8_q    <= '0;
            valid_q <= 1'b0;
            pe_q    <= '0;
            pv_q    <= 1'b0;
            en_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            k_q     <= k_d;
            ref_q   <= ref_d;
            refv_q  <= refv_d;
            zero_q  <= zero_d;
            e8_q    <= e8_d;
            valid_q <= valid_d;
            pe_q    <= pe_d;
            pv_q    <= pv_d;
            en_q    <= en_d;
            ovr_q   <= ovr_d;
        end
    end

    assign phaseError      = pe_q;
    assign phaseErrorValid = pv_q;
    assign phaseErrorEn    = en_q;
    assign overrun         = ovr_q;
    assign busy            = (state_q != S_IDLE);

endmodule
